// File: rtl/hub75_panel_rx.sv
// Panel-side HUB75 receiver: oversamples the stream, rebuilds each shifted row
// and commits the latched row pair into a frame buffer with a registered readback.
module hub75_panel_rx #(
    parameter int COLS        = 64,
    parameter int ROWS        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hub_sclk,
    input  logic                    A,
    input  logic                    B,
    input  logic                    C,
    input  logic                    D,
    input  logic                    R0,
    input  logic                    G0,
    input  logic                    B0,
    input  logic                    R1,
    input  logic                    G1,
    input  logic                    B1,
    input  logic                    LAT,
    input  logic                    OE,
    input  logic [$clog2(COLS)-1:0] rd_x,
    input  logic [$clog2(ROWS)-1:0] rd_y,
    output logic [2:0]              rd_rgb,
    output logic                    row_wr_done,
    output logic                    frame_done,
    output logic [3:0]              last_row,
    output logic                    len_err,
    output logic                    lat_overrun,
    output logic                    busy,
    output logic                    panel_on
);
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam int CW = $clog2(2 * COLS);
    localparam int IW = 13;
    localparam int SW = COLS * 6;
    localparam logic [CW-1:0] CNT_MAX  = CW'(2 * COLS - 1);
    localparam logic [CW-1:0] CNT_ROW  = CW'(COLS);
    localparam logic [XW-1:0] COL_LAST = XW'(COLS - 1);

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   w_in;
    logic [IW-1:0]   r_sync [SYNC_STAGES];
    logic [1:0]      r_prev;
    logic [IW-1:0]   w_s;
    logic            w_sclk_rise;
    logic            w_lat_rise;
    logic [SW-1:0]   r_shreg;
    logic [SW-1:0]   w_sh_next;
    logic [SW-1:0]   r_shadow;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_inc;
    logic [XW-1:0]   r_col;
    logic [3:0]      r_addr;
    logic [3:0]      r_last_row;
    logic            r_have;
    logic            r_len_err;
    logic            r_overrun;
    logic            r_panel_on;
    logic [2:0]      r_rd;
    logic            w_accept;
    logic            w_drop;
    logic            w_last;
    logic [2:0]      r_fb_up [ROWS/2][COLS];
    logic [2:0]      r_fb_lo [ROWS/2][COLS];

    assign w_in = {hub_sclk, LAT, OE, D, C, B, A, R0, G0, B0, R1, G1, B1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= w_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= r_sync[SYNC_STAGES-1][12:11];
        end
    end

    // Data, address and LAT are taken from the same stage as the shift clock.
    assign w_s         = r_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_s[12] & ~r_prev[1];
    assign w_lat_rise  = w_s[11] & ~r_prev[0];

    // A coincident shift is folded in before the latch sees the row and count.
    assign w_sh_next = w_sclk_rise ? {r_shreg[SW-7:0], w_s[5:0]} : r_shreg;
    assign w_cnt_inc = (w_sclk_rise && r_cnt != CNT_MAX) ? r_cnt + 1'b1 : r_cnt;

    always_ff @(posedge clk) begin
        r_shreg <= w_sh_next;
        if (w_accept) r_shadow <= w_sh_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_drop       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_lat_rise) begin
                    w_accept     = 1'b1;
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_drop = w_lat_rise;
                if (r_col == COL_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_col      <= '0;
            r_addr     <= '0;
            r_last_row <= '0;
            r_have     <= 1'b0;
            r_len_err  <= 1'b0;
            r_overrun  <= 1'b0;
            r_panel_on <= 1'b0;
        end else begin
            r_cnt      <= w_lat_rise ? '0 : w_cnt_inc;
            r_len_err  <= w_lat_rise && (w_cnt_inc != CNT_ROW);
            r_overrun  <= w_drop;
            r_panel_on <= ~w_s[10];
            if (w_accept) begin
                r_addr <= w_s[9:6];
                r_col  <= '0;
            end else if (r_state == S_WRITE) begin
                r_col <= r_col + 1'b1;
            end
            if (w_last) begin
                r_last_row <= r_addr;
                r_have     <= 1'b1;
            end
        end
    end

    // One shadow column per WRITE cycle, upper pixel to row addr, lower to addr+ROWS/2.
    always_ff @(posedge clk) begin
        if (r_state == S_WRITE) begin
            r_fb_up[r_addr][r_col] <= r_shadow[int'(r_col) * 6 + 3 +: 3];
            r_fb_lo[r_addr][r_col] <= r_shadow[int'(r_col) * 6 +: 3];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rd <= '0;
        else      r_rd <= rd_y[YW-1] ? r_fb_lo[rd_y[YW-2:0]][rd_x]
                                     : r_fb_up[rd_y[YW-2:0]][rd_x];
    end

    assign rd_rgb      = r_rd;
    assign busy        = (r_state == S_WRITE);
    assign row_wr_done = w_last;
    assign frame_done  = w_last && r_have && (r_addr <= r_last_row);
    assign last_row    = r_last_row;
    assign len_err     = r_len_err;
    assign lat_overrun = r_overrun;
    assign panel_on    = r_panel_on;

endmodule

// File: tb/tb_hub75_panel_rx.sv
// Randomized bench for hub75_panel_rx with a transaction-level reference model.
`timescale 1ns/1ps
module tb_hub75_panel_rx;
    localparam int COLS = 64;
    localparam int ROWS = 32;
    localparam int S    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sclk = 1'b0, lat = 1'b0, oe = 1'b1;
    logic [3:0] addr = '0;
    logic [5:0] pix = '0;
    logic [5:0] rd_x = '0;
    logic [4:0] rd_y = '0;
    logic [2:0] rd_rgb;
    logic       row_wr_done, frame_done, len_err, lat_overrun, busy, panel_on;
    logic [3:0] last_row;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hub75_panel_rx #(.COLS(COLS), .ROWS(ROWS), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .hub_sclk(sclk),
        .A(addr[0]), .B(addr[1]), .C(addr[2]), .D(addr[3]),
        .R0(pix[5]), .G0(pix[4]), .B0(pix[3]), .R1(pix[2]), .G1(pix[1]), .B1(pix[0]),
        .LAT(lat), .OE(oe), .rd_x(rd_x), .rd_y(rd_y), .rd_rgb(rd_rgb),
        .row_wr_done(row_wr_done), .frame_done(frame_done), .last_row(last_row),
        .len_err(len_err), .lat_overrun(lat_overrun), .busy(busy), .panel_on(panel_on)
    );

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endfunction

    // Reference model: pixels as a queue, writes as time windows, frame buffer as an array.
    logic [12:0] hist [0:S+1];
    logic [5:0]  pq[$];
    int          mcnt = 0, cyc = 0, ws = 0, le_cyc = -10, ov_cyc = -10;
    bit          act = 0, m_have = 0;
    logic [3:0]  waddr = '0, m_last = '0;
    logic [5:0]  wshadow [COLS];
    bit          wknown [COLS];
    logic [2:0]  fb [ROWS][COLS];
    bit          fbk [ROWS][COLS];
    logic        sev, lev, e_pan, prev_lat_in = 1'b0;
    logic [2:0]  e_rd;
    bit          rd_chk, wr_busy;
    int          cnt_rwd = 0, cnt_fd = 0, cnt_len = 0, cnt_ov = 0;
    int          brun = 0, blast = 0, lat_in_cyc = 0, rwd_cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (lat && !prev_lat_in) lat_in_cyc = cyc;
        prev_lat_in = lat;
        if (!rst) begin
            e_rd = 3'b000;
            rd_chk = 1'b1;
            if (act) for (int k = 0; k < COLS; k++) begin
                fbk[waddr][k] = 0;
                fbk[{1'b1, waddr}][k] = 0;
            end
            for (int i = 0; i <= S + 1; i++) hist[i] = '0;
            mcnt = 0; act = 0; m_have = 0; m_last = '0;
            le_cyc = -10; ov_cyc = -10; e_pan = 1'b0;
        end else begin
            rd_chk = fbk[rd_y][rd_x] && !(act && cyc >= ws + 1 && cyc <= ws + COLS);
            e_rd = fb[rd_y][rd_x];
            for (int i = S + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {sclk, lat, oe, addr, pix};
            e_pan = ~hist[S][10];
            sev = hist[S][12] & ~hist[S+1][12];
            lev = hist[S][11] & ~hist[S+1][11];
            wr_busy = act && cyc <= ws + COLS;
            if (sev) begin
                pq.push_back(hist[S][5:0]);
                if (pq.size() > COLS) void'(pq.pop_front());
                if (mcnt < 2 * COLS - 1) mcnt++;
            end
            if (lev) begin
                if (mcnt != COLS) le_cyc = cyc;
                if (wr_busy) ov_cyc = cyc;
                else begin
                    act = 1; ws = cyc; waddr = hist[S][9:6];
                    for (int k = 0; k < COLS; k++) begin
                        wknown[k] = (k < pq.size());
                        wshadow[k] = wknown[k] ? pq[pq.size() - 1 - k] : 6'd0;
                    end
                end
                mcnt = 0;
            end
            if (act && cyc == ws + COLS) begin
                for (int k = 0; k < COLS; k++) begin
                    fb[waddr][k] = wshadow[k][5:3];
                    fb[{1'b1, waddr}][k] = wshadow[k][2:0];
                    fbk[waddr][k] = wknown[k];
                    fbk[{1'b1, waddr}][k] = wknown[k];
                end
                m_last = waddr; m_have = 1; act = 0;
            end
        end
        #1;
        chk("busy", busy, act && cyc >= ws && cyc <= ws + COLS - 1);
        chk("row_wr_done", row_wr_done, act && cyc == ws + COLS - 1);
        chk("frame_done", frame_done, act && cyc == ws + COLS - 1 && m_have && waddr <= m_last);
        chk("last_row", last_row, m_last);
        chk("len_err", len_err, cyc == le_cyc);
        chk("lat_overrun", lat_overrun, cyc == ov_cyc);
        chk("panel_on", panel_on, e_pan);
        if (rd_chk) chk("rd_rgb", rd_rgb, e_rd);
        if (row_wr_done) begin cnt_rwd++; rwd_cyc = cyc; end
        if (frame_done) cnt_fd++;
        if (len_err) cnt_len++;
        if (lat_overrun) cnt_ov++;
        if (busy) brun++;
        else if (brun != 0) begin blast = brun; brun = 0; end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_px(input logic [5:0] p, input logic [3:0] a);
        pix = p; addr = a; sclk = 1'b0;
        if ($urandom_range(0, 15) == 0) oe = ~oe;
        tick(4);
        sclk = 1'b1;
        tick(4);
    endtask

    task automatic send_row(input logic [3:0] a, input int n, input bit fixed, input logic [5:0] pv);
        for (int i = 0; i < n; i++) shift_px(fixed ? pv : 6'($urandom), a);
        sclk = 1'b0;
        tick(4);
    endtask

    task automatic pulse_lat();
        lat = 1'b1; tick(4); lat = 1'b0; tick(2);
    endtask

    task automatic wait_done(input int bound);
        int s = cnt_rwd;
        int i = 0;
        while (cnt_rwd == s && i < bound) begin tick(1); i++; end
        chk("row_done_seen", cnt_rwd != s, 1);
        tick(4);
    endtask

    task automatic readback(input logic [5:0] x, input logic [4:0] y, input logic [2:0] exp);
        rd_x = x; rd_y = y;
        @(posedge clk); #2;
        chk("readback", rd_rgb, exp);
        @(negedge clk);
    endtask

    task automatic sweep(input logic [3:0] a);
        for (int i = 0; i < 8; i++) begin
            rd_x = 6'($urandom);
            rd_y = (i % 2 == 1) ? {1'b1, a} : {1'b0, a};
            tick(1);
        end
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_rwd"}, row_wr_done, 0);
        chk({nm, "_fd"}, frame_done, 0);
        chk({nm, "_last"}, last_row, 0);
        chk({nm, "_len"}, len_err, 0);
        chk({nm, "_ov"}, lat_overrun, 0);
        chk({nm, "_pan"}, panel_on, 0);
        chk({nm, "_rd"}, rd_rgb, 0);
    endtask

    initial begin
        int len0, ov0, fd0, rwd0, i;
        tick(3);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        tick(5);

        // Fixed row at address 3
        len0 = cnt_len;
        send_row(4'd3, COLS, 1, 6'b100001);
        pulse_lat();
        wait_done(300);
        chk("t1_len_err", cnt_len - len0, 0);
        chk("t1_latency", rwd_cyc - lat_in_cyc, 65);
        chk("t1_busy_len", blast, 64);
        chk("t1_last_row", last_row, 3);
        readback(6'd0, 5'd3, 3'b100);
        readback(6'd0, 5'd19, 3'b001);
        readback(6'd63, 5'd3, 3'b100);

        // Short row at address 5
        len0 = cnt_len;
        send_row(4'd5, COLS - 1, 0, 6'd0);
        pulse_lat();
        wait_done(300);
        chk("t2_len_err", cnt_len - len0, 1);
        chk("t2_last_row", last_row, 5);
        sweep(4'd5);

        // Second LAT 10 cycles after the first
        ov0 = cnt_ov; len0 = cnt_len;
        send_row(4'd7, COLS, 0, 6'd0);
        lat = 1'b1; tick(4); lat = 1'b0; addr = 4'd9; tick(6);
        lat = 1'b1; tick(4); lat = 1'b0;
        wait_done(300);
        chk("t3_overrun", cnt_ov - ov0, 1);
        chk("t3_len_err", cnt_len - len0, 1);
        chk("t3_last_row", last_row, 7);
        chk("t3_busy_len", blast, 64);
        sweep(4'd7);

        // Full frame after reset, then wrap to row 0
        rst = 1'b0; tick(2); rst = 1'b1; tick(3);
        fd0 = cnt_fd;
        for (int r = 0; r < 16; r++) begin
            send_row(4'(r), COLS, 0, 6'd0);
            pulse_lat();
            wait_done(300);
        end
        chk("t4_no_early_frame", cnt_fd - fd0, 0);
        chk("t4_last_row_15", last_row, 15);
        send_row(4'd0, COLS, 0, 6'd0);
        pulse_lat();
        wait_done(300);
        chk("t4_frame_done", cnt_fd - fd0, 1);
        chk("t4_last_row_0", last_row, 0);
        sweep(4'd0);

        // LAT and final sclk edge in the same cycle
        len0 = cnt_len;
        for (int k = 0; k < COLS - 1; k++) shift_px(6'($urandom), 4'd6);
        sclk = 1'b0; pix = 6'b010110; addr = 4'd6;
        tick(4);
        sclk = 1'b1; lat = 1'b1;
        tick(4);
        sclk = 1'b0; lat = 1'b0;
        wait_done(300);
        chk("t5_len_err", cnt_len - len0, 0);
        readback(6'd0, 5'd6, 3'b010);
        readback(6'd0, 5'd22, 3'b110);

        // Reset in the middle of a write
        rwd0 = cnt_rwd;
        send_row(4'd2, COLS, 0, 6'd0);
        lat = 1'b1;
        i = 0;
        while (!busy && i < 50) begin tick(1); i++; end
        chk("t6_busy_seen", busy, 1);
        lat = 1'b0;
        tick(30);
        rst = 1'b0;
        #1;
        check_all_zero("t6_abort");
        tick(3);
        rst = 1'b1;
        tick(5);
        chk("t6_no_done", cnt_rwd - rwd0, 0);
        send_row(4'd4, COLS, 0, 6'd0);
        pulse_lat();
        wait_done(300);
        chk("t6_clean_done", cnt_rwd - rwd0, 1);
        chk("t6_last_row", last_row, 4);
        sweep(4'd4);

        tick(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hub75_panel_rx.md
Name: hub75_panel_rx

Overview:
- Panel-side receiver for the HUB75 stream our matrix controller produces: row address A–D, six colour bits R0/G0/B0/R1/G1/B1, shift clock, LAT and OE.
- Oversamples every HUB75 line on the system clock and rebuilds the shifted row data.
- On each latch, commits the row pair into an on-chip frame buffer with a readback port.
- Used as a synthesizable loopback checker and as the bench scoreboard for the controller.

Parameters:
- COLS, 64, pixels per row; equals shifts expected between LAT pulses.
- ROWS, 32, panel rows; the upper half is addressed by {D,C,B,A}, the lower half by that address + ROWS/2.
- SYNC_STAGES, 2, synchronizer flops on every HUB75 input.

Ports:
- clk  in  1  system clock, at least 4x the HUB75 shift clock rate.
- rst  in  1  asynchronous active-low reset.
- hub_sclk  in  1  HUB75 shift clock; data is valid on its rising edge.
- A, B, C, D  in  1 each  row-pair address, A = LSB.
- R0, G0, B0  in  1 each  upper-half colour bits.
- R1, G1, B1  in  1 each  lower-half colour bits.
- LAT  in  1  latch strobe, active high.
- OE  in  1  output enable, active low.
- rd_x  in  $clog2(COLS)  readback column.
- rd_y  in  $clog2(ROWS)  readback row.
- rd_rgb  out  3  {R,G,B} at (rd_x, rd_y).
- row_wr_done  out  1  one-cycle pulse when a row-pair write completes.
- frame_done  out  1  one-cycle pulse on row-address wrap.
- last_row  out  4  address of the last committed row pair.
- len_err  out  1  one-cycle pulse when a LAT arrives with shift count != COLS.
- lat_overrun  out  1  one-cycle pulse when a LAT is dropped because a write is in progress.
- busy  out  1  high while the write FSM is in WRITE.
- panel_on  out  1  synchronized, inverted OE.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, every synchronizer flop 0, shift count 0, FSM IDLE. Frame-buffer contents are not reset; they are undefined until written.
- Synchronization:
  - All HUB75 inputs pass through SYNC_STAGES flops plus one edge-detect flop.
  - Data, address and LAT pass through the same depth as hub_sclk, so they keep their alignment with the shift clock.
- Shift:
  - Each detected hub_sclk rising edge shifts the synchronized {R0,G0,B0,R1,G1,B1} into a COLS-deep 6-bit shift register.
  - The first pixel shifted ends up at column COLS-1; the last ends up at column 0.
  - The shift count increments on each edge and saturates at 2*COLS-1.
- Latch (synchronized LAT rising edge):
  - If the shift count != COLS, pulse len_err; the commit proceeds regardless.
  - FSM IDLE: copy the shift register into the row shadow, capture the address, clear the shift count, go to WRITE.
  - FSM WRITE: pulse lat_overrun, drop this latch (shadow and address unchanged), and still clear the shift count.
- FSM WRITE:
  - Runs exactly COLS cycles.
  - Cycle k writes shadow column k to two locations: upper pixel (bits 5:3) to row addr, lower pixel (bits 2:0) to row addr + ROWS/2.
  - After the last column: pulse row_wr_done, update last_row, return to IDLE.
  - busy is high for exactly COLS cycles.
- frame_done:
  - Pulses in the same cycle as row_wr_done when the committed address is less than or equal to the previous last_row (wrap, or a repeated row).
  - Never pulses on the first commit after reset.
- Readback:
  - Registered, 1-cycle latency.
  - Same-cycle read and write to one address returns the old data.
- Simultaneous LAT edge and hub_sclk edge in one cycle: the shift is applied first, so it is included in the latched row and in the length check.
- Reset asserted mid-WRITE: the FSM aborts, no row_wr_done pulse, last_row returns to 0.

Test Plan:
- Reset, then shift 64 pixels of {1,0,0,0,0,1} at sclk = clk/8, address 3, then LAT → len_err stays 0; row_wr_done pulses 64 cycles after the synchronized LAT edge; rd (0,3) = 3'b100; rd (0,19) = 3'b001; last_row = 3.
- Shift 63 pixels, then LAT at address 5 → len_err pulses once; row 5 is still written.
- Second LAT 10 cycles after the first → lat_overrun pulses; last_row keeps the first address; busy stays high for exactly 64 cycles.
- Commit rows 0..15 in order, then row 0 → frame_done pulses only on the final commit.
- LAT edge and sclk edge in the same cycle after 63 shifts → len_err stays 0; the last pixel lands in column 0.
- rst driven low at cycle 30 of WRITE → all outputs 0 immediately; no row_wr_done pulse; the next clean row commits normally.
